// File: rtl/pcs_uart_pkg.sv
// Shared constants and types for the serial frame link (transmit and collect sides).
package pcs_uart_pkg;

    localparam int UART_DIV   = 16;
    localparam int UART_WIDTH = 32;

    localparam logic [UART_WIDTH-1:0] UART_IDLE_WORD = '1;

    // Snapshot format sized for the largest legal DIV (128) and WIDTH (32).
    localparam int TIMER_DIV_W = 7;
    localparam int TIMER_BIT_W = 5;

    typedef struct packed {
        logic [TIMER_DIV_W-1:0] div_cnt;
        logic [TIMER_BIT_W-1:0] bit_cnt;
    } frame_timer_t;

endpackage

// File: rtl/uart_frame_timer.sv
// Free-running bit/frame timer: one bit every DIV clocks, WIDTH bits per frame.
module uart_frame_timer
    import pcs_uart_pkg::*;
#(
    parameter int DIV   = UART_DIV,
    parameter int WIDTH = UART_WIDTH
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_bit_tick,
    output logic o_frame_end
);

    localparam int DIV_W = $clog2(DIV);
    localparam int BIT_W = $clog2(WIDTH);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [BIT_W-1:0] bit_cnt;

    assign o_bit_tick  = (div_cnt == DIV_LAST);
    assign o_frame_end = o_bit_tick && (bit_cnt == BIT_LAST);

    // NOTE: registered state uses <= so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            div_cnt <= '0;
            bit_cnt <= '0;
        end else if (o_bit_tick) begin
            div_cnt <= '0;
            bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_serialize.sv
// Serial frame transmitter: one-word holding buffer feeding an MSB-first shifter
// aligned to a free-running frame timer; empty frames go out as all-ones.
module uart_tx_serialize
    import pcs_uart_pkg::*;
#(
    parameter int DIV   = UART_DIV,
    parameter int WIDTH = UART_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ready,
    output logic             o_txd,
    output logic             o_frame_start,
    output logic             o_busy
);

    localparam logic [WIDTH-1:0] IDLE = UART_IDLE_WORD[WIDTH-1:0];

    logic             bit_tick;
    logic             frame_end;
    logic             take;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] hold_buf;
    logic             buf_full;
    logic             busy;
    logic             frame_start_d;

    uart_frame_timer #(
        .DIV   (DIV),
        .WIDTH (WIDTH)
    ) u_timer (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .o_bit_tick  (bit_tick),
        .o_frame_end (frame_end)
    );

    // The buffer frees up in the frame_end cycle, so a new word can land there.
    assign o_ready = !i_rst && (!buf_full || frame_end);
    assign take    = i_valid && o_ready;

    // NOTE: data-only register left unreset; buf_full alone says whether it is meaningful.
    always_ff @(posedge i_clk) begin
        if (take) begin
            hold_buf <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            shift_reg     <= IDLE;
            buf_full      <= 1'b0;
            busy          <= 1'b0;
            frame_start_d <= 1'b0;
            o_txd         <= 1'b1;
            o_frame_start <= 1'b0;
            o_busy        <= 1'b0;
        end else begin
            if (frame_end) begin
                shift_reg <= buf_full ? hold_buf : IDLE;
                busy      <= buf_full;
            end else if (bit_tick) begin
                shift_reg <= {shift_reg[WIDTH-2:0], 1'b1};
            end

            if (take) begin
                buf_full <= 1'b1;
            end else if (frame_end) begin
                buf_full <= 1'b0;
            end

            // Frame markers ride one stage behind shift_reg, matching the line register.
            frame_start_d <= frame_end;
            o_frame_start <= frame_start_d;
            o_busy        <= busy;
            o_txd         <= shift_reg[WIDTH-1];
        end
    end

endmodule

// File: tb/tb_uart_tx_serialize.sv
// Scoreboard bench for uart_tx_serialize: default instance plus a DIV=3/WIDTH=8 instance.
module tb_uart_tx_serialize;

    localparam int DIV   = 16;
    localparam int W     = 32;
    localparam int F     = DIV * W;
    localparam int S_DIV = 3;
    localparam int S_W   = 8;
    localparam int S_F   = S_DIV * S_W;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic [31:0] i_data = '0;
    logic        o_ready, o_txd, o_frame_start, o_busy;

    logic        s_valid = 1'b0;
    logic [7:0]  s_data = '0;
    logic        s_ready, s_txd, s_fs, s_busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rel_base = 0;

    logic [31:0] exp_q[$];
    logic [7:0]  s_exp_q[$];

    bit          mon_active = 0;
    bit          fs_valid = 0;
    int          last_fs_cyc = 0;
    int          mon_cnt = 0;
    logic [31:0] mon_word = '0;
    logic        mon_busy = 1'b0;
    bit          mon_busy_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_serialize #(.DIV(DIV), .WIDTH(W)) u_dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_valid       (i_valid),
        .i_data        (i_data),
        .o_ready       (o_ready),
        .o_txd         (o_txd),
        .o_frame_start (o_frame_start),
        .o_busy        (o_busy)
    );

    uart_tx_serialize #(.DIV(S_DIV), .WIDTH(S_W)) u_dut_small (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_valid       (s_valid),
        .i_data        (s_data),
        .o_ready       (s_ready),
        .o_txd         (s_txd),
        .o_frame_start (s_fs),
        .o_busy        (s_busy)
    );

    function automatic int rel();
        return cyc - rel_base + 1;
    endfunction

    // Line monitor: recovers each frame mid-bit and scores it against the queue.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (i_rst) begin
                mon_active = 0;
                fs_valid   = 0;
            end else begin
                if (o_frame_start) begin
                    if (fs_valid) begin
                        checks++;
                        if (cyc - last_fs_cyc != F) begin
                            errors++;
                            $display("FAIL frame_period got %0d cycles required %0d", cyc - last_fs_cyc, F);
                        end
                    end
                    fs_valid     = 1;
                    last_fs_cyc  = cyc;
                    mon_active   = 1;
                    mon_cnt      = 0;
                    mon_word     = '0;
                    mon_busy     = o_busy;
                    mon_busy_bad = 0;
                end else if (mon_active) begin
                    mon_cnt++;
                end
                if (mon_active) begin
                    if (o_busy !== mon_busy) mon_busy_bad = 1;
                    if (mon_cnt % DIV == DIV / 2) mon_word = {mon_word[W-2:0], o_txd};
                    if (mon_cnt == F - 1) begin
                        checks++;
                        if (mon_busy_bad) begin
                            errors++;
                            $display("FAIL busy_stable o_busy changed mid-frame, required constant %b", mon_busy);
                        end
                        checks++;
                        if (mon_busy === 1'b1) begin
                            if (exp_q.size() == 0) begin
                                errors++;
                                $display("FAIL frame_word got %h with no word expected", mon_word);
                            end else begin
                                e = exp_q.pop_front();
                                if (mon_word !== e) begin
                                    errors++;
                                    $display("FAIL frame_word got %h required %h", mon_word, e);
                                end
                            end
                        end else if (mon_word !== 32'hFFFF_FFFF) begin
                            errors++;
                            $display("FAIL idle_frame got %h required ffffffff", mon_word);
                        end
                        mon_active = 0;
                    end
                end
            end
        end
    end

    task automatic send(input logic [31:0] w, input int budget, output int acc);
        acc = -1;
        i_valid = 1'b1;
        for (int n = 0; n < budget; n++) begin
            i_data = w;
            #1;
            if (o_ready) begin
                exp_q.push_back(w);
                acc = cyc;
                @(negedge clk);
                break;
            end
            i_data = $urandom();
            @(negedge clk);
        end
        checks++;
        if (acc < 0) begin
            errors++;
            $display("FAIL send_timeout word %h not accepted within %0d cycles", w, budget);
        end
    endtask

    task automatic wait_drain(input int budget);
        for (int n = 0; n < budget; n++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout %0d words still pending, required 0", exp_q.size());
        end
    endtask

    task automatic do_reset();
        i_rst   = 1'b1;
        i_valid = 1'b0;
        s_valid = 1'b0;
        exp_q.delete();
        s_exp_q.delete();
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (o_txd !== 1'b1 || o_frame_start !== 1'b0 || o_busy !== 1'b0 || o_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs txd=%b fs=%b busy=%b ready=%b required 1 0 0 0",
                     o_txd, o_frame_start, o_busy, o_ready);
        end
        i_rst    = 1'b0;
        rel_base = cyc;
        #1;
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_release got %b required 1", o_ready);
        end
    endtask

    task automatic test_reset_idle();
        bit exp_fs;
        int r;
        do_reset();
        for (int n = 0; n < 3 * F + 20; n++) begin
            r = rel();
            exp_fs = (r >= F + 2) && ((r - (F + 2)) % F == 0);
            checks++;
            if (o_txd !== 1'b1 || o_busy !== 1'b0 || o_ready !== 1'b1 || o_frame_start !== exp_fs) begin
                errors++;
                $display("FAIL idle_line rel=%0d txd=%b busy=%b ready=%b fs=%b required 1 0 1 %b",
                         r, o_txd, o_busy, o_ready, o_frame_start, exp_fs);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_single_word();
        int acc;
        do_reset();
        while (rel() < 10) @(negedge clk);
        send(32'hA5A5_0F0F, 4, acc);
        i_valid = 1'b0;
        checks++;
        if (acc - rel_base + 1 != 10) begin
            errors++;
            $display("FAIL accept_cycle got rel %0d required 10", acc - rel_base + 1);
        end
        while (rel() <= 511) begin
            checks++;
            if (o_ready !== 1'b0) begin
                errors++;
                $display("FAIL ready_while_full rel=%0d got %b required 0", rel(), o_ready);
            end
            @(negedge clk);
        end
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_at_frame_end got %b required 1", o_ready);
        end
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b0 || o_frame_start !== 1'b0) begin
            errors++;
            $display("FAIL pre_frame rel=513 busy=%b fs=%b required 0 0", o_busy, o_frame_start);
        end
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b1 || o_frame_start !== 1'b1 || o_txd !== 1'b1) begin
            errors++;
            $display("FAIL first_bit rel=514 busy=%b fs=%b txd=%b required 1 1 1", o_busy, o_frame_start, o_txd);
        end
        while (rel() < 529) @(negedge clk);
        checks++;
        if (o_txd !== 1'b1) begin
            errors++;
            $display("FAIL bit0_last_cycle got %b required 1", o_txd);
        end
        @(negedge clk);
        checks++;
        if (o_txd !== 1'b0) begin
            errors++;
            $display("FAIL bit1_first_cycle got %b required 0", o_txd);
        end
        wait_drain(2 * F);
    endtask

    task automatic test_back_to_back();
        int c1, c2, c3;
        send(32'h0000_0001, 4, c1);
        send(32'h8000_0000, F + 4, c2);
        send(32'hFFFF_0000, F + 4, c3);
        i_valid = 1'b0;
        checks++;
        if (c3 - c2 != F) begin
            errors++;
            $display("FAIL b2b_accept_spacing got %0d required %0d", c3 - c2, F);
        end
        checks++;
        if (last_fs_cyc != c2 + 2) begin
            errors++;
            $display("FAIL b2b_frame_end_accept frame start at %0d required %0d", last_fs_cyc, c2 + 2);
        end
        while (cyc < c2 + 2 + 3 * F) begin
            checks++;
            if (o_busy !== 1'b1) begin
                errors++;
                $display("FAIL b2b_busy cycle %0d got %b required 1", cyc, o_busy);
            end
            @(negedge clk);
        end
        checks++;
        if (o_busy !== 1'b0 || o_frame_start !== 1'b1) begin
            errors++;
            $display("FAIL b2b_tail busy=%b fs=%b required 0 1", o_busy, o_frame_start);
        end
        wait_drain(2 * F);
    endtask

    task automatic test_frame_end_collision();
        int cx, t;
        send(32'h0F0F_F0F0, 4, cx);
        i_valid = 1'b0;
        t = last_fs_cyc - 2;
        while (t < cx + 3) t += F;
        while (cyc < t - 1) @(negedge clk);
        checks++;
        if (o_ready !== 1'b0) begin
            errors++;
            $display("FAIL collide_before got ready %b required 0", o_ready);
        end
        @(negedge clk);
        i_valid = 1'b1;
        i_data  = 32'h3C3C_C3C3;
        #1;
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL collide_ready got %b required 1", o_ready);
        end else begin
            exp_q.push_back(32'h3C3C_C3C3);
        end
        @(negedge clk);
        i_valid = 1'b0;
        checks++;
        if (o_ready !== 1'b0) begin
            errors++;
            $display("FAIL collide_buf_held got ready %b required 0", o_ready);
        end
        @(negedge clk);
        checks++;
        if (o_frame_start !== 1'b1 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL collide_frame fs=%b busy=%b required 1 1", o_frame_start, o_busy);
        end
        wait_drain(3 * F);
    endtask

    task automatic test_reset_mid_frame();
        int acc, fs;
        bit ok;
        send(32'h1234_5678, 4, acc);
        i_valid = 1'b0;
        ok = 0;
        fs = 0;
        for (int n = 0; n < 2 * F + 4; n++) begin
            if (o_frame_start && o_busy) begin
                ok = 1;
                fs = cyc;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rst_wait_frame no busy frame start seen, required one");
        end
        send(32'hDEAD_BEEF, 4, acc);
        i_valid = 1'b0;
        while (cyc < fs + 10 * DIV + DIV / 2) @(negedge clk);
        i_rst = 1'b1;
        #1;
        checks++;
        if (o_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_in_reset got %b required 0", o_ready);
        end
        exp_q.delete();
        @(negedge clk);
        checks++;
        if (o_txd !== 1'b1 || o_busy !== 1'b0 || o_frame_start !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_edge txd=%b busy=%b fs=%b required 1 0 0", o_txd, o_busy, o_frame_start);
        end
        i_rst    = 1'b0;
        rel_base = cyc;
        for (int n = 0; n < 2 * F + 8; n++) begin
            #1;
            checks++;
            if (o_txd !== 1'b1 || o_busy !== 1'b0 || o_ready !== 1'b1) begin
                errors++;
                $display("FAIL post_reset_idle rel=%0d txd=%b busy=%b ready=%b required 1 0 1",
                         rel(), o_txd, o_busy, o_ready);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_param_small();
        bit          ok;
        logic [7:0]  e;
        s_valid = 1'b1;
        s_data  = 8'hC3;
        ok = 0;
        for (int n = 0; n < S_F + 4; n++) begin
            #1;
            if (s_ready) begin
                s_exp_q.push_back(8'hC3);
                ok = 1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        s_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL small_send_timeout word c3 not accepted");
        end
        ok = 0;
        for (int n = 0; n < 3 * S_F; n++) begin
            if (s_fs && s_busy) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!ok || s_exp_q.size() == 0) begin
            errors++;
            $display("FAIL small_frame_start no busy frame seen (seen=%b), required one", ok);
        end else begin
            e = s_exp_q.pop_front();
            for (int i = 0; i < S_F; i++) begin
                checks++;
                if (s_txd !== e[S_W-1-(i/S_DIV)] || s_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL small_bit cycle %0d txd=%b busy=%b required %b 1",
                             i, s_txd, s_busy, e[S_W-1-(i/S_DIV)]);
                end
                @(negedge clk);
            end
            checks++;
            if (s_fs !== 1'b1 || s_busy !== 1'b0) begin
                errors++;
                $display("FAIL small_frame_len fs=%b busy=%b at cycle %0d required 1 0", s_fs, s_busy, S_F);
            end
        end
    endtask

    initial begin
        test_reset_idle();
        test_single_word();
        test_back_to_back();
        test_frame_end_collision();
        test_reset_mid_frame();
        test_param_small();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_serialize.md
Name: uart_tx_serialize

Overview:
- Transmit end of the team's free-running 32-bit serial frame link.
- Accepts parallel words over a valid/ready handshake and holds up to one pending word.
- Shifts each word MSB-first onto a single line, one bit every DIV clocks.
- Frame alignment is free-running. Frames with nothing to send are all-ones (line high), matching the collector's idle/reset value of all-ones.

Parameters:
- DIV, 16, clocks per bit; legal range 2..128.
- WIDTH, 32, bits per frame; legal range 2..32.

Ports:
- i_clk  input  1  system clock.
- i_rst  input  1  synchronous reset, active-high. Sampled on the i_clk rising edge only.
- i_valid  input  1  upstream word-valid.
- i_data  input  WIDTH  upstream word; sampled when i_valid && o_ready.
- o_ready  output  1  holding buffer can accept a word this cycle.
- o_txd  output  1  serial line; idle = 1.
- o_frame_start  output  1  one-cycle pulse, high in the first cycle of every frame.
- o_busy  output  1  high while the current frame carries user data (not idle all-ones).

Behaviour:
- Reset (i_rst=1 at a clock edge):
  - div_cnt=0, bit_cnt=0, shift_reg=all-ones, buf_full=0, busy=0.
  - o_txd=1, o_frame_start=0, o_busy=0.
  - o_ready is forced 0 while i_rst=1.
  - Reset mid-frame aborts the word being shifted and drops any pending word. The line returns high the cycle after the reset edge.
- div_cnt: counts 0..DIV-1 every cycle, then wraps to 0.
- bit_tick: asserted when div_cnt==DIV-1.
- bit_cnt: increments on bit_tick and wraps from WIDTH-1 to 0.
- frame_end: asserted when bit_tick && bit_cnt==WIDTH-1. Frame length is DIV*WIDTH clocks (512 at defaults). The first frame_end is the (DIV*WIDTH)-th cycle after reset release.
- Shift: on bit_tick && !frame_end, shift_reg <= {shift_reg[WIDTH-2:0],1'b1}.
- On frame_end, shift_reg is loaded from the holding buffer:
  - If buf_full: shift_reg <= buf, busy <= 1, buf_full <= 0.
  - Otherwise: shift_reg <= all-ones, busy <= 0.
- o_txd is registered: o_txd <= shift_reg[WIDTH-1] every cycle. The line therefore lags shift_reg by one cycle; this is fixed and identical for every bit.
- Bit k (k=0 is the MSB) of a loaded word is driven on o_txd for DIV consecutive cycles. These start 2+k*DIV cycles after the frame_end edge that loaded it.
- o_frame_start is registered and aligned with o_txd: high in the cycle o_txd first shows bit 0 of a new frame.
- o_busy is registered, changes in that same cycle, and stays constant for the whole frame.
- Handshake:
  - o_ready = !i_rst && (!buf_full || frame_end).
  - Transfer occurs when i_valid && o_ready; then buf <= i_data and buf_full <= 1.
- Simultaneous frame_end, buf_full and transfer: the old buffer content goes to shift_reg and the new word goes to the buffer. buf_full stays 1, with no bubble and no loss.
- Back-to-back: with i_valid held high, consecutive frames carry consecutive words with no idle frame between them.
- Acceptance latency:
  - A word taken while the buffer is empty appears on the line at the next frame boundary, i.e. 2..DIV*WIDTH+1 cycles later.
  - i_data changing while !o_ready has no effect.
- Width rules:
  - div_cnt is $clog2(DIV) bits and bit_cnt is $clog2(WIDTH) bits, both compared against the parameter minus 1.
  - No dependence on power-of-two values.

Decomposition:
- Shared package pcs_uart_pkg holds:
  - UART_DIV=16, UART_WIDTH=32, and UART_IDLE_WORD='1.
  - A frame_timer struct {div_cnt, bit_cnt}.
- The collector is updated to import the same package.
- One sub-module: uart_frame_timer. It holds the div_cnt/bit_cnt counters and outputs bit_tick and frame_end. It has the same sync active-high reset and is reusable by the receive side.

Test Plan:
- Reset release, no i_valid for 3 frames -> o_txd=1 every cycle; o_frame_start pulses every 512 cycles; o_busy=0; o_ready=1.
- Send 32'hA5A5_0F0F at cycle 10 after reset -> o_ready drops until cycle 511. o_txd shows bits 1,0,1,0,... with 16 cycles each, starting at the o_frame_start pulse, with o_busy=1. A serial-to-parallel model sampling mid-bit recovers 32'hA5A5_0F0F.
- i_valid held with words 32'h0000_0001, 32'h8000_0000, 32'hFFFF_0000 -> three consecutive busy frames, no idle frame between. The second word is accepted in the frame_end cycle of the first frame.
- Word offered at exactly a frame_end cycle with buffer full -> both words are transmitted in order, and o_ready stays high that cycle.
- Reset asserted at bit 10 of a 32'h1234_5678 frame with a pending word -> o_txd=1 the next cycle. The pending word is never sent, the next frame is idle all-ones, and o_busy=0.
- Parameter run DIV=3, WIDTH=8, word 8'hC3 -> frame=24 cycles with bits 1,1,0,0,0,0,1,1 at 3 cycles each.
